mii_tx_mac: RTL and testbench

MAC-side MII transmit engine: it converts a byte stream with a valid/ready handshake into MII nibbles on `txd`/`tx_en`/`tx_er`. The block generates the preamble and SFD, pads short frames, appends the CRC-32 FCS and enforces the inter-frame gap. It sits between the MAC frame source and the `Mac` modport of the MII interface bundle, and runs entirely in the PHY-supplied `tx_clk` domain.

---
 rtl/eth_pkg.sv | 27 ++
 rtl/crc32_nibble.sv | 20 ++
 rtl/mii_tx_mac.sv | 196 +++++++++++++++++++
 tb/tb_mii_tx_mac.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet constants, MII transmit FSM states and small helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package eth_pkg;

    localparam logic [3:0]  ETH_PREAMBLE_NIBBLE = 4'h5;
    localparam logic [3:0]  ETH_SFD_NIBBLE      = 4'hD;
    localparam int          ETH_MIN_PAYLOAD     = 60;
    localparam logic [31:0] CRC32_POLY_REFL     = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT          = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        DATA,
        PAD,
        FCS,
        ABORT,
        IFG
    } mii_tx_state_t;

    // Byte counter increment that sticks at its maximum instead of wrapping.
    function automatic logic [10:0] sat_inc11(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

endpackage

// File: rtl/crc32_nibble.sv
// One nibble step of the reflected Ethernet CRC-32 (LSB of the nibble first).
// Latency: purely combinational.
// Backpressure: none; caller decides when to register the result.
module crc32_nibble
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [3:0]  nibble,
    output logic [31:0] crc_out
);

    // Fold the nibble into the low bits, then shift four times through the reflected polynomial.
    always_comb begin
        crc_out = crc_in ^ {28'h0, nibble};
        for (int i = 0; i < 4; i++) begin
            crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC32_POLY_REFL) : (crc_out >> 1);
        end
    end

endmodule

// File: rtl/mii_tx_mac.sv
// MII transmit MAC: byte stream in, preamble/SFD + payload + pad + FCS nibbles out, then IFG.
// Latency: s_valid seen in IDLE at edge k -> first preamble nibble registered at edge k+1.
// Backpressure: s_ready only on the SFD cycle, each high-nibble cycle (not after s_last) and in ABORT.
module mii_tx_mac
    import eth_pkg::*;
#(
    parameter bit PAD_EN    = 1'b1,
    parameter int IFG_BYTES = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [3:0] txd,
    output logic       tx_en,
    output logic       tx_er,
    output logic       frame_done,
    output logic       underrun
);

    // The IDLE cycle that follows IFG is also a tx_en-low cycle, so IFG itself runs one short.
    localparam int IFG_LAST = 2 * IFG_BYTES - 2;
    localparam int CNT_W    = (IFG_LAST > 15) ? $clog2(IFG_LAST + 1) : 4;

    mii_tx_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [10:0]      bcnt_q, bcnt_d;
    logic             hi_q, hi_d;
    logic [7:0]       byte_q, byte_d;
    logic             last_q, last_d;
    logic [31:0]      crc_q, crc_d;
    logic [3:0]       txd_q, txd_d;
    logic             tx_en_q, tx_en_d;
    logic             tx_er_q, tx_er_d;
    logic             frame_done_q, frame_done_d;
    logic             underrun_q, underrun_d;

    logic [3:0]  crc_nib;
    logic [31:0] crc_nxt;
    logic [31:0] crc_fin;

    crc32_nibble u_crc (
        .crc_in  (crc_q),
        .nibble  (crc_nib),
        .crc_out (crc_nxt)
    );

    assign crc_fin = ~crc_q;

    assign s_ready = ((state_q == PREAMBLE) && (cnt_q == CNT_W'(15)))
                   || ((state_q == DATA) && hi_q && !last_q)
                   || (state_q == ABORT);

    assign txd        = txd_q;
    assign tx_en      = tx_en_q;
    assign tx_er      = tx_er_q;
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;

    // Next-state and next-output logic; outputs are registered one edge after the state that makes them.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bcnt_d       = bcnt_q;
        hi_d         = hi_q;
        byte_d       = byte_q;
        last_d       = last_q;
        crc_d        = crc_q;
        crc_nib      = 4'h0;
        txd_d        = 4'h0;
        tx_en_d      = 1'b0;
        tx_er_d      = 1'b0;
        frame_done_d = 1'b0;
        underrun_d   = 1'b0;
        case (state_q)
            IDLE: begin
                crc_d  = CRC32_INIT;
                bcnt_d = 11'd0;
                cnt_d  = '0;
                hi_d   = 1'b0;
                last_d = 1'b0;
                if (s_valid) state_d = PREAMBLE;
            end
            PREAMBLE: begin
                tx_en_d = 1'b1;
                txd_d   = (cnt_q == CNT_W'(15)) ? ETH_SFD_NIBBLE : ETH_PREAMBLE_NIBBLE;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(15)) begin
                    cnt_d = '0;
                    hi_d  = 1'b0;
                    if (s_valid) begin
                        byte_d  = s_data;
                        last_d  = s_last;
                        bcnt_d  = 11'd1;
                        state_d = DATA;
                    end else begin
                        underrun_d = 1'b1;
                        state_d    = ABORT;
                    end
                end
            end
            DATA: begin
                tx_en_d = 1'b1;
                crc_nib = hi_q ? byte_q[7:4] : byte_q[3:0];
                txd_d   = crc_nib;
                crc_d   = crc_nxt;
                hi_d    = ~hi_q;
                if (hi_q) begin
                    if (last_q) begin
                        cnt_d   = '0;
                        state_d = (PAD_EN && (bcnt_q < 11'(ETH_MIN_PAYLOAD))) ? PAD : FCS;
                    end else if (s_valid) begin
                        byte_d = s_data;
                        last_d = s_last;
                        bcnt_d = sat_inc11(bcnt_q);
                    end else begin
                        underrun_d = 1'b1;
                        state_d    = ABORT;
                    end
                end
            end
            PAD: begin
                tx_en_d = 1'b1;
                crc_nib = 4'h0;
                txd_d   = 4'h0;
                crc_d   = crc_nxt;
                hi_d    = ~hi_q;
                if (hi_q) begin
                    bcnt_d = sat_inc11(bcnt_q);
                    if (bcnt_q == 11'(ETH_MIN_PAYLOAD - 1)) begin
                        cnt_d   = '0;
                        state_d = FCS;
                    end
                end
            end
            FCS: begin
                tx_en_d = 1'b1;
                txd_d   = crc_fin[{cnt_q[2:0], 2'b00} +: 4];
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(7)) begin
                    frame_done_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = IFG;
                end
            end
            ABORT: begin
                tx_en_d = 1'b1;
                tx_er_d = 1'b1;
                if (s_valid && s_last) begin
                    frame_done_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = IFG;
                end
            end
            IFG: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(IFG_LAST)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops tx_en immediately and re-arms the CRC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bcnt_q       <= 11'd0;
            hi_q         <= 1'b0;
            byte_q       <= 8'h00;
            last_q       <= 1'b0;
            crc_q        <= CRC32_INIT;
            txd_q        <= 4'h0;
            tx_en_q      <= 1'b0;
            tx_er_q      <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bcnt_q       <= bcnt_d;
            hi_q         <= hi_d;
            byte_q       <= byte_d;
            last_q       <= last_d;
            crc_q        <= crc_d;
            txd_q        <= txd_d;
            tx_en_q      <= tx_en_d;
            tx_er_q      <= tx_er_d;
            frame_done_q <= frame_done_d;
            underrun_q   <= underrun_d;
        end
    end

endmodule

// File: tb/tb_mii_tx_mac.sv
// Bench for mii_tx_mac: one unpadded and one padded instance, table vectors, corner sequences, random frames.
// Latency: n/a.
// Backpressure: driver honours s_ready sampled mid-cycle.
module tb_mii_tx_mac;

    logic       clk;
    logic       rst_n;

    logic [7:0] d0, d1;
    logic       v0, v1, l0, l1;
    logic       r0, r1;
    logic [3:0] txd0, txd1;
    logic       en0, en1, er0, er1, fd0, fd1, ur0, ur1;

    mii_tx_mac #(.PAD_EN(1'b0), .IFG_BYTES(12)) dut_np (
        .clk(clk), .rst_n(rst_n), .s_data(d0), .s_valid(v0), .s_last(l0), .s_ready(r0),
        .txd(txd0), .tx_en(en0), .tx_er(er0), .frame_done(fd0), .underrun(ur0)
    );

    mii_tx_mac #(.PAD_EN(1'b1), .IFG_BYTES(12)) dut_p (
        .clk(clk), .rst_n(rst_n), .s_data(d1), .s_valid(v1), .s_last(l1), .s_ready(r1),
        .txd(txd1), .tx_en(en1), .tx_er(er1), .frame_done(fd1), .underrun(ur1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic sel = 1'b0;   // which instance the monitor watches and the driver feeds

    logic [7:0] pl [0:1535];
    logic [3:0] exp_nibs [$];

    // Monitor state
    logic [3:0] mon_nibs [$];
    int frames_done = 0;
    int mon_er = 0, mon_fd = 0, mon_fd_idx = -1, mon_ur = 0;
    int low_run = 0, low_rdy = 0, mon_gap = 0, mon_gap_rdy = 0;
    logic mon_prev_en = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Capture every tx_en-high burst on the selected instance, plus gap length before it.
    initial begin
        forever begin
            logic m_en, m_er, m_fd, m_ur, m_rdy;
            logic [3:0] m_txd;
            @(negedge clk);
            m_en  = sel ? en1  : en0;
            m_er  = sel ? er1  : er0;
            m_fd  = sel ? fd1  : fd0;
            m_ur  = sel ? ur1  : ur0;
            m_rdy = sel ? r1   : r0;
            m_txd = sel ? txd1 : txd0;
            if (m_en) begin
                if (!mon_prev_en) begin
                    mon_gap     = low_run;
                    mon_gap_rdy = low_rdy;
                    mon_nibs.delete();
                    mon_er = 0; mon_fd = 0; mon_fd_idx = -1; mon_ur = 0;
                end
                mon_nibs.push_back(m_txd);
                if (m_er) mon_er++;
                if (m_fd) begin mon_fd++; mon_fd_idx = mon_nibs.size() - 1; end
                if (m_ur) mon_ur++;
                low_run = 0;
                low_rdy = 0;
            end else begin
                if (mon_prev_en) frames_done++;
                if (m_fd) begin mon_fd++; mon_fd_idx = mon_nibs.size(); end
                if (m_ur) mon_ur++;
                low_run++;
                if (m_rdy) low_rdy++;
            end
            mon_prev_en = m_en;
        end
    end

    task automatic fill(input int n, input int pat);
        for (int i = 0; i < n; i++) begin
            case (pat)
                0:       pl[i] = 8'h31 + 8'(i);
                1:       pl[i] = 8'(i * 7 + 3);
                default: pl[i] = 8'($urandom);
            endcase
        end
    endtask

    // Reference frame: preamble/SFD, payload (padded to 60 if asked), bit-serial CRC-32 FCS.
    // With abort_after >= 0 the frame stops after that many bytes and n-abort_after zero nibbles follow.
    task automatic build_exp(input int n, input bit pad, input int abort_after);
        logic [31:0] crc;
        logic [31:0] fcs;
        logic [7:0]  b;
        logic        fb;
        int          tot;
        exp_nibs.delete();
        for (int i = 0; i < 15; i++) exp_nibs.push_back(4'h5);
        exp_nibs.push_back(4'hD);
        if (abort_after >= 0) begin
            for (int i = 0; i < abort_after; i++) begin
                b = pl[i];
                exp_nibs.push_back(b[3:0]);
                exp_nibs.push_back(b[7:4]);
            end
            for (int i = abort_after; i < n; i++) exp_nibs.push_back(4'h0);
        end else begin
            crc = 32'hFFFFFFFF;
            tot = (pad && n < 60) ? 60 : n;
            for (int i = 0; i < tot; i++) begin
                b = (i < n) ? pl[i] : 8'h00;
                exp_nibs.push_back(b[3:0]);
                exp_nibs.push_back(b[7:4]);
                for (int k = 0; k < 8; k++) begin
                    fb  = crc[0] ^ b[k];
                    crc = {1'b0, crc[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
                end
            end
            fcs = ~crc;
            for (int k = 0; k < 8; k++) exp_nibs.push_back(fcs[4*k +: 4]);
        end
    endtask

    task automatic set_in(input logic s, input logic v, input logic [7:0] d, input logic l);
        if (s) begin v1 = v; d1 = d; l1 = l; end
        else   begin v0 = v; d0 = d; l0 = l; end
    endtask

    // Stream n bytes; optionally withhold s_valid for one ready cycle once drop_after bytes are in.
    task automatic drive(input logic s, input int n, input int drop_after);
        int   i = 0;
        int   guard = 0;
        bit   dropped = 0;
        logic acc;
        while (i < n && guard < 4000) begin
            @(negedge clk);
            guard++;
            if (!rst_n) break;
            if (drop_after >= 0 && i == drop_after && !dropped && (s ? r1 : r0)) begin
                set_in(s, 1'b0, pl[i], 1'b0);
                dropped = 1;
                @(posedge clk);
                continue;
            end
            set_in(s, 1'b1, pl[i], (i == n - 1));
            acc = s ? r1 : r0;
            @(posedge clk);
            if (acc) i++;
        end
    endtask

    task automatic check_frame(input string tag, input int base, input int width_exp,
                               input bit chk_gap, input int exp_er, input int exp_ur);
        int guard = 0;
        int mism  = -1;
        int lim;
        while (frames_done == base && guard < 5000) begin
            @(posedge clk);
            guard++;
        end
        check({tag, ".done"}, frames_done - base, 1);
        if (frames_done == base) return;
        check({tag, ".width"}, mon_nibs.size(), width_exp);
        lim = (mon_nibs.size() < exp_nibs.size()) ? mon_nibs.size() : exp_nibs.size();
        for (int i = 0; i < lim; i++) begin
            if (mon_nibs[i] !== exp_nibs[i] && mism < 0) mism = i;
        end
        if (mism < 0 && mon_nibs.size() != exp_nibs.size()) mism = lim;
        check({tag, ".nibble_mismatch_at"}, mism, -1);
        check({tag, ".frame_done_cnt"}, mon_fd, 1);
        check({tag, ".frame_done_pos"}, mon_fd_idx, width_exp - 1);
        check({tag, ".tx_er_cnt"}, mon_er, exp_er);
        check({tag, ".underrun_cnt"}, mon_ur, exp_ur);
        if (chk_gap) begin
            check({tag, ".ifg_len"}, mon_gap, 24);
            check({tag, ".ifg_ready"}, mon_gap_rdy, 0);
        end
    endtask

    typedef struct {
        logic        s;
        int          len;
        int          pat;
        int          width;
        bit          chk_fcs;
        logic [31:0] fcs;
    } vec_t;

    initial begin
        vec_t vecs [8];
        int   base;
        logic [31:0] got_fcs;
        logic prev_s;
        int   len;

        vecs[0] = '{1'b0,  9, 0,  42, 1'b1, 32'hCBF43926};
        vecs[1] = '{1'b1, 14, 1, 144, 1'b0, 32'h0};
        vecs[2] = '{1'b1, 59, 1, 144, 1'b0, 32'h0};
        vecs[3] = '{1'b1, 60, 2, 144, 1'b0, 32'h0};
        vecs[4] = '{1'b1, 61, 1, 146, 1'b0, 32'h0};
        vecs[5] = '{1'b0,  1, 1,  26, 1'b0, 32'h0};
        vecs[6] = '{1'b1,  1, 2, 144, 1'b0, 32'h0};
        vecs[7] = '{1'b0, 64, 2, 152, 1'b0, 32'h0};

        v0 = 0; v1 = 0; d0 = 0; d1 = 0; l0 = 0; l1 = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_outputs_np", {txd0, en0, er0, fd0, ur0, r0}, 0);
        check("reset_outputs_p",  {txd1, en1, er1, fd1, ur1, r1}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Table-driven single frames, each from an idle line
        for (int t = 0; t < 8; t++) begin
            sel = vecs[t].s;
            fill(vecs[t].len, vecs[t].pat);
            build_exp(vecs[t].len, vecs[t].s, -1);
            base = frames_done;
            fork
                drive(vecs[t].s, vecs[t].len, -1);
                check_frame($sformatf("vec%0d", t), base, vecs[t].width, 1'b0, 0, 0);
            join
            if (vecs[t].chk_fcs && mon_nibs.size() >= 8) begin
                for (int k = 0; k < 8; k++) got_fcs[4*k +: 4] = mon_nibs[mon_nibs.size() - 8 + k];
                check($sformatf("vec%0d.fcs", t), {32'h0, got_fcs}, {32'h0, vecs[t].fcs});
            end
            @(negedge clk);
            set_in(vecs[t].s, 1'b0, 8'h00, 1'b0);
            repeat (40) @(posedge clk);
        end

        // Back-to-back frames with s_valid held high across the gap
        sel = 1'b1;
        fill(20, 1);
        build_exp(20, 1'b1, -1);
        base = frames_done;
        fork
            drive(1'b1, 20, -1);
            check_frame("b2b_a", base, 144, 1'b0, 0, 0);
        join
        fill(70, 2);
        build_exp(70, 1'b1, -1);
        base = frames_done;
        fork
            drive(1'b1, 70, -1);
            check_frame("b2b_b", base, 164, 1'b1, 0, 0);
        join

        // Underrun after 20 bytes, then a clean frame straight after the abort's IFG
        fill(40, 1);
        build_exp(40, 1'b1, 20);
        base = frames_done;
        fork
            drive(1'b1, 40, 20);
            check_frame("underrun", base, 76, 1'b1, 20, 1);
        join
        fill(30, 2);
        build_exp(30, 1'b1, -1);
        base = frames_done;
        fork
            drive(1'b1, 30, -1);
            check_frame("after_abort", base, 144, 1'b1, 0, 0);
        join
        @(negedge clk);
        set_in(1'b1, 1'b0, 8'h00, 1'b0);
        repeat (40) @(posedge clk);

        // Reset in the middle of the payload
        fill(200, 2);
        fork
            drive(1'b1, 200, -1);
            begin
                repeat (100) @(posedge clk);
                #2;
                check("pre_reset_tx_en", en1, 1);
                #1 rst_n = 1'b0;
                #1;
                check("midframe_reset_outputs", {txd1, en1, er1, fd1, ur1, r1}, 0);
            end
        join
        @(negedge clk);
        set_in(1'b1, 1'b0, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        fill(33, 2);
        build_exp(33, 1'b1, -1);
        base = frames_done;
        fork
            drive(1'b1, 33, -1);
            check_frame("post_reset", base, 144, 1'b0, 0, 0);
        join
        @(negedge clk);
        set_in(1'b1, 1'b0, 8'h00, 1'b0);
        repeat (40) @(posedge clk);

        // Random frames, back-to-back whenever the same instance is used twice in a row
        prev_s = sel;
        for (int f = 0; f < 200; f++) begin
            logic s;
            s = 1'($urandom_range(0, 1));
            if (f == 0) len = 1500;
            else if ($urandom_range(0, 19) == 0) len = $urandom_range(1, 1500);
            else len = $urandom_range(1, 64);
            if (f == 0 || s != prev_s) begin
                @(negedge clk);
                set_in(prev_s, 1'b0, 8'h00, 1'b0);
                @(posedge clk);
                sel = s;
            end
            fill(len, 2);
            build_exp(len, s, -1);
            base = frames_done;
            fork
                drive(s, len, -1);
                check_frame($sformatf("rand%0d", f), base, exp_nibs.size(),
                            (f > 0 && s == prev_s), 0, 0);
            join
            prev_s = s;
        end
        @(negedge clk);
        set_in(prev_s, 1'b0, 8'h00, 1'b0);
        repeat (5) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
